// File: rtl/led_pwm_decoder.sv
// led_pwm_decoder: recovers 8-bit R/G/B duty codes from fixed-period PWM
// waveforms by measuring high-run lengths on each channel independently.
module led_pwm_chan #(
    parameter int PERIOD = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pwm,
    output logic [7:0] duty,
    output logic       upd,
    output logic       stuck_low
);
    typedef enum logic [1:0] {SYNC, LOW, HIGH} state_t;

    localparam logic [8:0] LAST = 9'(PERIOD - 1);
    localparam logic [8:0] TOP  = 9'(PERIOD);
    localparam logic [7:0] FULL = 8'(PERIOD - 1);

    logic       meta;
    logic       s;
    logic       s_d;
    logic       rise;
    logic       fall;
    state_t     state;
    logic [8:0] lcnt;
    logic [8:0] hcnt;
    logic       sat;

    // Left unreset so a pulse in flight at reset release is seen as high
    // and discarded by SYNC rather than mistaken for a low sample.
    always_ff @(posedge clk) begin
        meta <= pwm;
        s    <= meta;
        s_d  <= s;
    end

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SYNC;
            lcnt      <= 9'd0;
            hcnt      <= 9'd0;
            sat       <= 1'b0;
            duty      <= 8'd0;
            upd       <= 1'b0;
            stuck_low <= 1'b0;
        end else begin
            upd <= 1'b0;
            unique case (state)
                SYNC: begin
                    if (!s) begin
                        state <= LOW;
                        lcnt  <= 9'd1;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state     <= HIGH;
                        hcnt      <= 9'd1;
                        sat       <= 1'b0;
                        stuck_low <= 1'b0;
                    end else if (!s && lcnt != TOP) begin
                        lcnt <= lcnt + 9'd1;
                        if (lcnt == LAST) begin
                            duty      <= 8'd0;
                            upd       <= 1'b1;
                            stuck_low <= 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state <= LOW;
                        lcnt  <= 9'd1;
                        if (!sat) begin
                            duty <= hcnt[7:0] - 8'd1;
                            upd  <= 1'b1;
                        end
                    end else if (s) begin
                        // Constant high re-reports full scale every period.
                        if (hcnt == LAST) begin
                            duty <= FULL;
                            upd  <= 1'b1;
                            sat  <= 1'b1;
                            hcnt <= 9'd0;
                        end else begin
                            hcnt <= hcnt + 9'd1;
                        end
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end
endmodule

module led_pwm_decoder #(
    parameter int PERIOD = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pwm_r,
    input  logic       pwm_g,
    input  logic       pwm_b,
    output logic [7:0] duty_r,
    output logic [7:0] duty_g,
    output logic [7:0] duty_b,
    output logic [2:0] upd,
    output logic [2:0] stuck_low
);
    led_pwm_chan #(.PERIOD(PERIOD)) u_r (
        .clk       (clk),
        .reset     (reset),
        .pwm       (pwm_r),
        .duty      (duty_r),
        .upd       (upd[0]),
        .stuck_low (stuck_low[0])
    );

    led_pwm_chan #(.PERIOD(PERIOD)) u_g (
        .clk       (clk),
        .reset     (reset),
        .pwm       (pwm_g),
        .duty      (duty_g),
        .upd       (upd[1]),
        .stuck_low (stuck_low[1])
    );

    led_pwm_chan #(.PERIOD(PERIOD)) u_b (
        .clk       (clk),
        .reset     (reset),
        .pwm       (pwm_b),
        .duty      (duty_b),
        .upd       (upd[2]),
        .stuck_low (stuck_low[2])
    );
endmodule
